key_onehot_capture: RTL

Captures eight raw push-button inputs and turns them into a clean, latched one-hot key vector with an enable flag. This is the stage directly upstream of the 8-to-3 encoder: `onehot_out` drives the encoder's data input and `enable_out` drives its enable. The block synchronises and debounces the buttons, accepts a press only when exactly one key is down, and holds that result until a new press is accepted or `clear` is asserted.

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_onehot_capture_if.sv | 27 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/key_onehot_capture.sv | 92 +++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key capture path: key count, FSM state
// encodings and a one-hot test used when deciding whether a press is valid.
package key_pkg;

  localparam int N_KEYS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      ones += int'(v[i]);
    end
    return ones == 1;
  endfunction

endpackage

// File: rtl/key_onehot_capture_if.sv
// Bundle of the key capture signals.
//   key_in      raw buttons (master -> slave)
//   clear       drop latched key (master -> slave)
//   onehot_out  latched one-hot key (slave -> master)
//   enable_out  latched key valid (slave -> master)
//   press_pulse one-cycle strobe on new key (slave -> master)
//   multi_err   one-cycle strobe on multi-key press (slave -> master)
interface key_onehot_capture_if;
  import key_pkg::*;

  logic [N_KEYS-1:0] key_in;
  logic              clear;
  logic [N_KEYS-1:0] onehot_out;
  logic              enable_out;
  logic              press_pulse;
  logic              multi_err;

  modport master (
    output key_in, clear,
    input  onehot_out, enable_out, press_pulse, multi_err
  );

  modport slave (
    input  key_in, clear,
    output onehot_out, enable_out, press_pulse, multi_err
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer. A change on
// the synchronised vector is only passed to dout after it has been stable
// for DEBOUNCE_CYCLES consecutive clocks; any bit change restarts the count.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   din    raw asynchronous inputs
//   dout   debounced vector
module key_debounce
  import key_pkg::*;
#(
  parameter int WIDTH           = N_KEYS,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter saturates here; the stable candidate is published.
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/key_onehot_capture.sv
// Push-button front end for the 8-to-3 encoder. Debounces the raw keys,
// latches a press only when exactly one key is down and holds it until a
// new press is accepted or clear is asserted.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    key_onehot_capture_if.slave (key_in, clear in; onehot_out,
//          enable_out, press_pulse, multi_err out)
//
// state   | meaning
// ST_IDLE | no key down; next debounced press is evaluated
// ST_HELD | a press was evaluated; waiting for all keys released
module key_onehot_capture
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_onehot_capture_if.slave  bus
);

  logic [N_KEYS-1:0] deb;

  key_debounce #(
    .WIDTH          (N_KEYS),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.key_in),
    .dout (deb)
  );

  state_e            state_q, state_d;
  logic [N_KEYS-1:0] onehot_q, onehot_d;
  logic              enable_q, enable_d;
  logic              press_q, press_d;
  logic              multi_q, multi_d;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    enable_d = enable_q;
    press_d  = 1'b0;
    multi_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (deb != '0) begin
          state_d = ST_HELD;
          if (is_onehot(deb)) begin
            onehot_d = deb;
            enable_d = 1'b1;
            press_d  = 1'b1;
          end else begin
            multi_d = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (deb == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear only empties the latch; the pulse and state move still happen.
    if (bus.clear) begin
      onehot_d = '0;
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
      enable_q <= 1'b0;
      press_q  <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      enable_q <= enable_d;
      press_q  <= press_d;
      multi_q  <= multi_d;
    end
  end

  assign bus.onehot_out  = onehot_q;
  assign bus.enable_out  = enable_q;
  assign bus.press_pulse = press_q;
  assign bus.multi_err   = multi_q;

endmodule
